// File: rtl/spi_slave_driver_if.sv
// spi_slave_driver_if
//   Bundles the system-side ready/valid signals and the four SPI wires of
//   one SPI mode-0 slave link.
//   slave modport  : the spi_slave_driver end (drives tx_ready, rx_data,
//                    rx_valid, tx_underrun, busy, miso).
//   master modport : the attached logic plus the SPI master (drives tx_data,
//                    tx_load, sclk, cs, mosi).
interface spi_slave_driver_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_load;
  logic                  tx_ready;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  tx_underrun;
  logic                  busy;
  logic                  sclk;
  logic                  cs;
  logic                  mosi;
  logic                  miso;

  modport slave (
    input  tx_data, tx_load, sclk, cs, mosi,
    output tx_ready, rx_data, rx_valid, tx_underrun, busy, miso
  );

  modport master (
    output tx_data, tx_load, sclk, cs, mosi,
    input  tx_ready, rx_data, rx_valid, tx_underrun, busy, miso
  );
endinterface

// File: rtl/spi_slave_driver.sv
// spi_slave_driver
//   SPI mode-0 slave. SCLK, CS and MOSI are oversampled through synchronizers
//   in the clk domain. A single-entry tx buffer feeds a shift register that
//   drives MISO MSB first; MOSI is assembled into rx_data, flagged by a
//   one-cycle rx_valid pulse. Several words may be sent under one CS.
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-high reset
//   bus  - spi_slave_driver_if.slave: tx_data/tx_load/tx_ready buffer write,
//          rx_data/rx_valid received word, tx_underrun pulse, busy,
//          sclk/cs/mosi/miso SPI pins
module spi_slave_driver #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input logic               clk,
  input logic               rst,
  spi_slave_driver_if.slave bus
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  state_t state, next_state;

  logic [SYNC_STAGES-1:0] sclk_pipe, cs_pipe, mosi_pipe;
  logic                   sclk_d, cs_d;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

  logic [DATA_WIDTH-1:0]  tx_buf, tx_shift, rx_shift, rx_data_q;
  logic                   buf_full, word_done, rx_valid_q, underrun_q;
  logic [CNT_W-1:0]       bit_count;
  logic                   consume, active;

  // Input synchronizers plus one extra registered copy of sclk and cs for
  // edge detection. cs resets high so the link comes up deselected.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_pipe <= '0;
      cs_pipe   <= '1;
      mosi_pipe <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sclk_pipe <= {sclk_pipe[SYNC_STAGES-2:0], bus.sclk};
      cs_pipe   <= {cs_pipe[SYNC_STAGES-2:0], bus.cs};
      mosi_pipe <= {mosi_pipe[SYNC_STAGES-2:0], bus.mosi};
      sclk_d    <= sclk_pipe[SYNC_STAGES-1];
      cs_d      <= cs_pipe[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_pipe[SYNC_STAGES-1];
  assign cs_s      = cs_pipe[SYNC_STAGES-1];
  assign mosi_s    = mosi_pipe[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_rise   = cs_s & ~cs_d;
  assign cs_fall   = ~cs_s & cs_d;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic. A cs rise seen during LOAD drops straight back to
  // IDLE so a short CS glitch cannot strand the FSM in SHIFT.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (cs_fall) next_state = LOAD;
      LOAD:    next_state = cs_rise ? IDLE : SHIFT;
      SHIFT:   if (cs_rise) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // SCLK edges only count while shifting and not in the cycle CS releases.
  assign active  = (state == SHIFT) && !cs_rise;
  // The buffer is consumed at the start of a transfer and on the falling
  // edge that closes each completed word (back-to-back reload).
  assign consume = (state == LOAD) || (active && sclk_fall && word_done);

  // Tx buffer and tx shift register. The consume is evaluated against the
  // old buffer state, so a tx_load in the same cycle as an empty-buffer
  // consume still lands in the buffer for the following word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_buf     <= '0;
      buf_full   <= 1'b0;
      tx_shift   <= '0;
      underrun_q <= 1'b0;
    end else begin
      underrun_q <= 1'b0;
      if (consume) begin
        if (buf_full) begin
          tx_shift <= tx_buf;
        end else begin
          tx_shift   <= '0;
          underrun_q <= 1'b1;
        end
      end else if (active && sclk_fall) begin
        tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
      end
      if (bus.tx_load && !buf_full) begin
        tx_buf   <= bus.tx_data;
        buf_full <= 1'b1;
      end else if (consume) begin
        buf_full <= 1'b0;
      end
    end
  end

  // Receive path and bit counter. Leaving SHIFT (or a mid-word CS release)
  // clears the count and drops the partial word without touching rx_data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_shift   <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      bit_count  <= '0;
      word_done  <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      if (!active) begin
        bit_count <= '0;
        word_done <= 1'b0;
      end else if (sclk_rise) begin
        rx_shift <= {rx_shift[DATA_WIDTH-2:0], mosi_s};
        if (bit_count == LAST_BIT) begin
          bit_count  <= '0;
          rx_data_q  <= {rx_shift[DATA_WIDTH-2:0], mosi_s};
          rx_valid_q <= 1'b1;
          word_done  <= 1'b1;
        end else begin
          bit_count <= bit_count + CNT_W'(1);
        end
      end else if (sclk_fall && word_done) begin
        word_done <= 1'b0;
      end
    end
  end

  assign bus.miso        = (state == SHIFT) ? tx_shift[DATA_WIDTH-1] : 1'b0;
  assign bus.busy        = ~cs_s;
  assign bus.tx_ready    = ~buf_full;
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.tx_underrun = underrun_q;

endmodule

// File: tb/tb_spi_slave_driver.sv
// tb_spi_slave_driver
//   Directed bench for spi_slave_driver: plays the SPI master (half-period
//   HALF clk cycles, mode 0) and the attached system logic, comparing MISO
//   streams, received words and pulse counts with hand-computed values.
module tb_spi_slave_driver;

  localparam int HALF = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks   = 0;
  int failures = 0;
  int rx_pulses = 0;
  int ur_pulses = 0;

  spi_slave_driver_if #(.DATA_WIDTH(8)) bus ();

  spi_slave_driver #(
    .DATA_WIDTH (8),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled away from the active edge.
  always @(negedge clk) begin
    if (bus.rx_valid === 1'b1)    rx_pulses++;
    if (bus.tx_underrun === 1'b1) ur_pulses++;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic load_tx(input logic [7:0] d);
    bus.tx_data = d;
    bus.tx_load = 1'b1;
    @(negedge clk);
    bus.tx_load = 1'b0;
  endtask

  task automatic cs_assert();
    bus.cs = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic cs_release();
    bus.cs = 1'b1;
    repeat (6) @(negedge clk);
    bus.sclk = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  // Clocks nbits bits MSB first. When last is set, SCLK stays high after the
  // final rising edge so CS can be released before it falls.
  task automatic spi_bits(input logic [7:0] mosi_word, input int nbits,
                          input bit last, output logic [7:0] miso_word);
    miso_word = '0;
    for (int i = 7; i >= 8 - nbits; i--) begin
      bus.mosi = mosi_word[i];
      repeat (HALF) @(negedge clk);
      miso_word[i] = bus.miso;
      bus.sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      if (!(last && i == 8 - nbits)) bus.sclk = 1'b0;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (bus.tx_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_tx_ready got=%b exp=1", bus.tx_ready); end
    checks++; if (bus.rx_data !== 8'h00) begin failures++; $display("[TB] FAIL reset_rx_data got=%h exp=00", bus.rx_data); end
    checks++; if (bus.rx_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_rx_valid got=%b exp=0", bus.rx_valid); end
    checks++; if (bus.tx_underrun !== 1'b0) begin failures++; $display("[TB] FAIL reset_underrun got=%b exp=0", bus.tx_underrun); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.miso !== 1'b0) begin failures++; $display("[TB] FAIL reset_miso got=%b exp=0", bus.miso); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_single_word();
    logic [7:0] got;
    load_tx(8'hA5);
    checks++; if (bus.tx_ready !== 1'b0) begin failures++; $display("[TB] FAIL single_buf_full got=%b exp=0", bus.tx_ready); end
    rx_pulses = 0;
    cs_assert();
    checks++; if (bus.tx_ready !== 1'b1) begin failures++; $display("[TB] FAIL single_ready_after_load got=%b exp=1", bus.tx_ready); end
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("[TB] FAIL single_busy got=%b exp=1", bus.busy); end
    checks++; if (bus.miso !== 1'b1) begin failures++; $display("[TB] FAIL single_msb_early got=%b exp=1", bus.miso); end
    spi_bits(8'h3C, 8, 1'b1, got);
    checks++; if (got !== 8'hA5) begin failures++; $display("[TB] FAIL single_miso got=%h exp=a5", got); end
    checks++; if (bus.rx_data !== 8'h3C) begin failures++; $display("[TB] FAIL single_rx_data got=%h exp=3c", bus.rx_data); end
    checks++; if (rx_pulses !== 1) begin failures++; $display("[TB] FAIL single_rx_pulses got=%0d exp=1", rx_pulses); end
    cs_release();
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL single_busy_idle got=%b exp=0", bus.busy); end
  endtask

  task automatic test_underrun();
    logic [7:0] got;
    ur_pulses = 0;
    rx_pulses = 0;
    cs_assert();
    spi_bits(8'h81, 8, 1'b1, got);
    cs_release();
    checks++; if (ur_pulses !== 1) begin failures++; $display("[TB] FAIL underrun_pulses got=%0d exp=1", ur_pulses); end
    checks++; if (got !== 8'h00) begin failures++; $display("[TB] FAIL underrun_miso got=%h exp=00", got); end
    checks++; if (bus.rx_data !== 8'h81) begin failures++; $display("[TB] FAIL underrun_rx_data got=%h exp=81", bus.rx_data); end
    checks++; if (rx_pulses !== 1) begin failures++; $display("[TB] FAIL underrun_rx_pulses got=%0d exp=1", rx_pulses); end
  endtask

  task automatic test_abort();
    logic [7:0] got;
    rx_pulses = 0;
    cs_assert();
    spi_bits(8'hFF, 5, 1'b1, got);
    cs_release();
    checks++; if (rx_pulses !== 0) begin failures++; $display("[TB] FAIL abort_rx_pulses got=%0d exp=0", rx_pulses); end
    checks++; if (bus.rx_data !== 8'h81) begin failures++; $display("[TB] FAIL abort_rx_hold got=%h exp=81", bus.rx_data); end
    load_tx(8'hC6);
    cs_assert();
    spi_bits(8'h5A, 8, 1'b1, got);
    cs_release();
    checks++; if (bus.rx_data !== 8'h5A) begin failures++; $display("[TB] FAIL abort_next_rx got=%h exp=5a", bus.rx_data); end
    checks++; if (rx_pulses !== 1) begin failures++; $display("[TB] FAIL abort_next_pulses got=%0d exp=1", rx_pulses); end
    checks++; if (got !== 8'hC6) begin failures++; $display("[TB] FAIL abort_next_miso got=%h exp=c6", got); end
  endtask

  task automatic test_load_reject();
    logic [7:0] got;
    load_tx(8'h66);
    checks++; if (bus.tx_ready !== 1'b0) begin failures++; $display("[TB] FAIL reject_ready got=%b exp=0", bus.tx_ready); end
    load_tx(8'h77);
    cs_assert();
    spi_bits(8'h24, 8, 1'b1, got);
    cs_release();
    checks++; if (got !== 8'h66) begin failures++; $display("[TB] FAIL reject_miso got=%h exp=66", got); end
    checks++; if (bus.rx_data !== 8'h24) begin failures++; $display("[TB] FAIL reject_rx_data got=%h exp=24", bus.rx_data); end
    checks++; if (bus.tx_ready !== 1'b1) begin failures++; $display("[TB] FAIL reject_buf_empty got=%b exp=1", bus.tx_ready); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] got1, got2;
    rx_pulses = 0;
    ur_pulses = 0;
    load_tx(8'h11);
    cs_assert();
    checks++; if (bus.tx_ready !== 1'b1) begin failures++; $display("[TB] FAIL b2b_ready got=%b exp=1", bus.tx_ready); end
    load_tx(8'h22);
    checks++; if (bus.tx_ready !== 1'b0) begin failures++; $display("[TB] FAIL b2b_second_full got=%b exp=0", bus.tx_ready); end
    spi_bits(8'hF0, 8, 1'b0, got1);
    checks++; if (bus.rx_data !== 8'hF0) begin failures++; $display("[TB] FAIL b2b_rx_first got=%h exp=f0", bus.rx_data); end
    spi_bits(8'h0F, 8, 1'b1, got2);
    cs_release();
    checks++; if (got1 !== 8'h11) begin failures++; $display("[TB] FAIL b2b_miso_first got=%h exp=11", got1); end
    checks++; if (got2 !== 8'h22) begin failures++; $display("[TB] FAIL b2b_miso_second got=%h exp=22", got2); end
    checks++; if (bus.rx_data !== 8'h0F) begin failures++; $display("[TB] FAIL b2b_rx_second got=%h exp=0f", bus.rx_data); end
    checks++; if (rx_pulses !== 2) begin failures++; $display("[TB] FAIL b2b_rx_pulses got=%0d exp=2", rx_pulses); end
    checks++; if (ur_pulses !== 0) begin failures++; $display("[TB] FAIL b2b_underrun got=%0d exp=0", ur_pulses); end
  endtask

  task automatic test_reset_mid_transfer();
    logic [7:0] got;
    load_tx(8'h99);
    cs_assert();
    load_tx(8'hAA);
    spi_bits(8'hE7, 3, 1'b0, got);
    repeat (4) @(negedge clk);
    checks++; if (bus.miso !== 1'b1) begin failures++; $display("[TB] FAIL rstmid_pre_miso got=%b exp=1", bus.miso); end
    checks++; if (bus.tx_ready !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_pre_ready got=%b exp=0", bus.tx_ready); end
    rst = 1'b1;
    bus.cs = 1'b1;
    #1;
    checks++; if (bus.miso !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_miso got=%b exp=0", bus.miso); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.tx_ready !== 1'b1) begin failures++; $display("[TB] FAIL rstmid_ready got=%b exp=1", bus.tx_ready); end
    checks++; if (bus.rx_data !== 8'h00) begin failures++; $display("[TB] FAIL rstmid_rx_data got=%h exp=00", bus.rx_data); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    rx_pulses = 0;
    load_tx(8'h3E);
    cs_assert();
    spi_bits(8'hC3, 8, 1'b1, got);
    cs_release();
    checks++; if (got !== 8'h3E) begin failures++; $display("[TB] FAIL rstmid_after_miso got=%h exp=3e", got); end
    checks++; if (bus.rx_data !== 8'hC3) begin failures++; $display("[TB] FAIL rstmid_after_rx got=%h exp=c3", bus.rx_data); end
    checks++; if (rx_pulses !== 1) begin failures++; $display("[TB] FAIL rstmid_after_pulses got=%0d exp=1", rx_pulses); end
  endtask

  initial begin
    bus.tx_data = 8'h00;
    bus.tx_load = 1'b0;
    bus.sclk    = 1'b0;
    bus.cs      = 1'b1;
    bus.mosi    = 1'b0;
    test_reset();
    test_single_word();
    test_underrun();
    test_abort();
    test_load_reject();
    test_back_to_back();
    test_reset_mid_transfer();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_slave_driver.md
Name: spi_slave_driver

Overview:
- SPI mode-0 slave: the responder end of the link driven by the team's SPI master.
- Oversamples SCLK, CS and MOSI in the system clock domain.
- Shifts a buffered transmit word out on MISO, MSB first, and assembles the received MOSI word.
- Presents a ready/valid system interface to the attached computational logic.

Parameters:
- DATA_WIDTH, 8, bits per SPI word; must be ≥ 2.
- SYNC_STAGES, 2, flops in each input synchronizer for sclk, cs and mosi; must be ≥ 2.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-high.
- tx_data  input  DATA_WIDTH  word to send on the next transfer.
- tx_load  input  1  writes tx_data into the tx buffer when tx_ready=1; ignored otherwise.
- tx_ready  output  1  tx buffer empty, can accept tx_load.
- rx_data  output  DATA_WIDTH  last complete word received; held until the next completion.
- rx_valid  output  1  one-cycle pulse, rx_data updated this cycle.
- tx_underrun  output  1  one-cycle pulse, a word started with the tx buffer empty.
- busy  output  1  synchronized CS is low.
- sclk  input  1  SPI clock from the master; idle low.
- cs  input  1  chip select, active-low.
- mosi  input  1  master-out data.
- miso  output  1  slave-out data.

Behaviour:
- Reset values: tx_ready=1, rx_data=0, rx_valid=0, tx_underrun=0, busy=0, miso=0. Synchronizer flops reset as cs=1, sclk=0, mosi=0. Internal bit counter and shift registers are cleared.
- Synchronization: sclk, cs and mosi each pass through SYNC_STAGES flops. Edges are detected by comparing the last synchronized stage with one more registered copy.
  - Edge-to-action latency is SYNC_STAGES+1 clk cycles.
  - The SCLK half-period must be ≥ SYNC_STAGES+2 clk cycles; the bench guarantees this.
- States:
  - IDLE: synchronized cs=1, miso=0, busy=0.
    - Synchronized cs falling edge → LOAD.
  - LOAD: one cycle.
    - If the tx buffer is full, move it into tx_shift and set tx_ready=1.
    - If the buffer is empty, load all zeros into tx_shift and pulse tx_underrun.
    - bit_count=0 → SHIFT.
  - SHIFT:
    - miso = tx_shift MSB.
    - sclk rising edge: rx_shift <= {rx_shift[DATA_WIDTH-2:0], mosi_sync}; bit_count increments.
    - When bit_count reaches DATA_WIDTH: rx_data <= assembled word and rx_valid=1 on the same cycle; bit_count returns to 0.
    - sclk falling edge: tx_shift shifts left by one, zero fill.
    - Falling edge that follows a completed word: tx_shift reloads from the buffer using the LOAD rules (underrun rules included). This supports back-to-back words under one CS assertion.
    - Synchronized cs rising edge → IDLE.
- cs rising mid-word: the partial rx word is discarded, with no rx_valid and no rx_data change. bit_count clears. The tx word already moved to tx_shift is lost. The buffer is not touched.
- tx_load in the same cycle as LOAD/reload consuming the buffer: the consume happens first. If the buffer was empty, the new word is written and is sent on the next word, and the underrun pulse still fires. If the buffer was full, tx_ready was 0, so the load is ignored.
- tx_load while tx_ready=0 is ignored; no overwrite.
- sclk edges while synchronized cs=1 are ignored.
- Asynchronous rst mid-transfer returns every signal to its reset value immediately. The transfer resumes only at the next cs falling edge after rst deassertion.
- MISO timing: the MSB is valid SYNC_STAGES+2 cycles after the CS fall. The master's first rising edge comes no earlier than one half-period after the CS fall.

Test Plan:
- Single word:
  - Stimulus: tx_load 8'hA5, then master sends 8'h3C at half-period 8 clk.
  - Response: miso bit stream 1,0,1,0,0,1,0,1; rx_data=8'h3C with one rx_valid pulse after the 8th rising edge; tx_ready=1 after LOAD.
- Back-to-back:
  - Stimulus: 8'h11 and 8'h22 preloaded in turn; two words sent under one CS (mosi 8'hF0, 8'h0F).
  - Response: miso 8'h11 then 8'h22; rx_valid twice with rx_data 8'hF0 then 8'h0F.
- Underrun:
  - Stimulus: CS falls with nothing loaded; master sends 8'h81.
  - Response: tx_underrun pulses once, miso is all 0, rx_data=8'h81.
- Abort:
  - Stimulus: CS rises after 5 sclk rising edges.
  - Response: no rx_valid, rx_data keeps its previous value; the next full word 8'h5A is received correctly.
- Load rejection:
  - Stimulus: tx_load 8'h77 while tx_ready=0 (buffer holds 8'h66).
  - Response: the next transfer sends 8'h66.
- Reset:
  - Stimulus: assert rst during bit 3.
  - Response: miso=0, busy=0, tx_ready=1 immediately; a later full transfer of 8'hC3 is received correctly.
